// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and word geometry for the program loader
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LANES = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: packs incoming bytes little-endian into a 32-bit word with per-lane enables
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        full
);

    // the byte about to be pushed closes the word when it lands in the top lane
    assign full = lane == 2'(LANES - 1);

    // lane counter, word buffer and enable accumulator; clear wins over push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            word <= '0;
            be   <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
            be   <= '0;
        end else if (push) begin
            word[{lane, 3'b000} +: 8] <= data;
            be[lane]                  <= 1'b1;
            lane                      <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a byte image into instruction memory as word writes, holding the core in reset until loaded
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 40,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    output logic              core_rst_n,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] byte_cnt
);

    state_t            state, next;
    logic              accept, store, restart, clear, lane_full, last_q;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       word;
    logic [ADDR_W-1:0] word_addr;

    assign accept  = s_valid && s_ready;
    assign store   = accept && (byte_cnt < ADDR_W'(DEPTH));
    assign restart = start && (state == IDLE || state == DONE);
    assign clear   = restart || state == WRITE;
    assign wr_addr = word_addr;
    assign wr_data = word;
    assign wr_be   = be;

    word_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (store),
        .data  (s_data),
        .lane  (lane),
        .word  (word),
        .be    (be),
        .full  (lane_full)
    );

    // next state: a stored closing byte or a discarded last byte with pending lanes writes; a discarded last byte alone finishes
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? LOAD : state;
            LOAD: begin
                if (store && (lane_full || s_last))
                    next = WRITE;
                else if (accept && !store && s_last)
                    next = (|be) ? WRITE : DONE;
            end
            WRITE: next = last_q ? DONE : LOAD;
            default: next = IDLE;
        endcase
    end

    // state, counters and registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            err        <= 1'b0;
            last_q     <= 1'b0;
            word_addr  <= '0;
            s_ready    <= 1'b0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= next;
            s_ready    <= next == LOAD;
            wr_en      <= next == WRITE;
            done       <= next == DONE;
            core_rst_n <= next == DONE;
            if (restart) begin
                byte_cnt <= '0;
                err      <= 1'b0;
                last_q   <= 1'b0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + ADDR_W'(1);
                last_q   <= s_last;
                if (!store)
                    err <= 1'b1;
                if (store && lane == 2'd0)
                    word_addr <= byte_cnt;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench comparing loader writes against an image-level reference model
module tb_imem_loader;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic              clk, rst_n, start, s_valid, s_ready, s_last, wr_en, core_rst_n, done, err;
    logic [7:0]        s_data;
    logic [ADDR_W-1:0] wr_addr, byte_cnt;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err),
        .byte_cnt   (byte_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every write strobe pops the next expected word from the scoreboard
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h be %h expected none", wr_addr, wr_data, wr_be);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                check("wr_be", {28'd0, wr_be}, {28'd0, e.be});
            end
            check("s_ready_in_write", {31'd0, s_ready}, 32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 0);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 0);
        check({tag, "_wr_be"}, {28'd0, wr_be}, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_err"}, {31'd0, err}, 0);
        check({tag, "_byte_cnt"}, byte_cnt, 0);
    endtask

    task automatic pulse_start();
        logic was_done;
        @(negedge clk);
        was_done = done;
        start = 1;
        @(negedge clk);
        start = 0;
        check("start_s_ready", {31'd0, s_ready}, 1);
        if (was_done) begin
            check("restart_core_rst_n", {31'd0, core_rst_n}, 0);
            check("restart_done", {31'd0, done}, 0);
            check("restart_err", {31'd0, err}, 0);
            check("restart_byte_cnt", byte_cnt, 0);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit gaps);
        int t = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        s_data = d;
        s_last = l;
        s_valid = 1;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got s_ready 0 expected 1");
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // reference: byte i below DEPTH lands at address i, grouped into aligned words
    task automatic model(input bq_t b);
        for (int w = 0; w * 4 < b.size() && w * 4 < DEPTH; w++) begin
            wr_t e;
            e.addr = 32'(w * 4);
            e.data = 0;
            e.be   = 0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < b.size() && w * 4 + k < DEPTH) begin
                    e.data[8*k +: 8] = b[w*4+k];
                    e.be[k] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run_load(input bq_t b, input bit gaps, input int mid_start);
        int t = 0;
        model(b);
        pulse_start();
        for (int i = 0; i < b.size(); i++) begin
            if (i == mid_start) begin
                s_valid = 0;
                @(negedge clk);
                start = 1;
                @(negedge clk);
                start = 0;
            end
            send(b[i], i == b.size() - 1, gaps);
        end
        s_valid = 0;
        s_last = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("done", {31'd0, done}, 1);
        check("core_rst_n", {31'd0, core_rst_n}, 1);
        check("s_ready_done", {31'd0, s_ready}, 0);
        check("byte_cnt", byte_cnt, 32'(b.size()));
        check("err", {31'd0, err}, {31'd0, b.size() > DEPTH});
        check("writes_outstanding", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t b;
        rst_n = 0;
        start = 0;
        s_valid = 0;
        s_data = 0;
        s_last = 0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        b = '{8'h93, 8'h97, 8'h17, 8'h00, 8'h03, 8'ha8, 8'h88, 8'h00};
        run_load(b, 0, -1);
        run_load(b, 1, -1);
        b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hb3};
        run_load(b, 0, -1);
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a};
        run_load(b, 0, -1);
        pulse_start();
        send(8'haa, 0, 0);
        send(8'hbb, 0, 0);
        s_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_load(b, 0, 2);
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 12);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            run_load(b, 1, (r % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory, the write-side counterpart of the core's byte-addressed, little-endian instruction fetch path. It accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one little-endian 32-bit word. It then issues word writes with byte enables into the instruction memory and holds the core in reset until the image is fully loaded.

## Interface
- DEPTH, 40: instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 32: width of `wr_addr` and `byte_cnt`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that begins a load.
- s_valid  in  1  byte stream valid.
- s_ready  out  1  loader can accept a byte.
- s_data  in  8  stream byte; first byte goes to address 0.
- s_last  in  1  marks the final byte of the image; qualified by s_valid.
- wr_en  out  1  memory word write strobe, one cycle.
- wr_addr  out  ADDR_W  byte address of the word; always a multiple of 4.
- wr_data  out  32  little-endian word: byte at addr+0 in [7:0], addr+3 in [31:24].
- wr_be  out  4  byte enables; bit i enables byte lane i.
- core_rst_n  out  1  core reset, active-low; high only in DONE.
- done  out  1  load complete.
- err  out  1  sticky overflow flag, cleared by start.
- byte_cnt  out  ADDR_W  bytes accepted in the current load, including discarded bytes.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: accepting bytes.
  - WRITE: one-cycle memory write.
  - DONE: image loaded.
- Outputs in reset: state=IDLE; s_ready, wr_en, wr_be, wr_addr, wr_data, core_rst_n, done, err, byte_cnt, lane all 0.
- Start, lane and byte handling:
  - `start` moves IDLE or DONE to LOAD. On that edge it clears byte_cnt, lane, err, the word buffer and the buffer byte enables.
  - `start` is ignored in LOAD and WRITE.
  - A byte is accepted when s_valid && s_ready.
  - s_ready is 1 only in LOAD.
  - An accepted byte with byte_cnt < DEPTH is stored in buffer lane `lane`, sets buffer enable bit `lane`, and increments lane mod 4.
  - Every accepted byte increments byte_cnt.
- Leaving LOAD:
  - An accepted byte that fills lane 3, or that has s_last=1 with at least one buffered lane, moves LOAD to WRITE.
  - In WRITE: wr_en=1, wr_addr = byte_cnt of the first byte in the word, wr_data = buffer (unfilled lanes zero), wr_be = buffer enables.
  - WRITE then clears the buffer. It goes to DONE if the word was closed by s_last, otherwise back to LOAD.
- Overflow:
  - An accepted byte with byte_cnt ≥ DEPTH is discarded and sets err.
  - If that byte has s_last=1 and no lanes are buffered, LOAD goes directly to DONE.
- An empty image (no bytes before s_last) is not possible; s_last always rides on a byte.
- DONE: done=1, core_rst_n=1, s_ready=0. The state holds until `start` or reset.
- Asynchronous reset mid-load returns to IDLE immediately. Partially buffered bytes are dropped and no write is issued.

## Timing
- wr_en is asserted in the cycle after the edge that accepted the word-closing byte; latency is 1 cycle.
- s_ready is 0 during WRITE, so a held s_valid byte is accepted on the cycle after WRITE. Maximum throughput is 4 bytes per 5 cycles.
- done and core_rst_n rise in the cycle after the final WRITE, or the cycle after the accepting edge on the overflow path.
- core_rst_n drops in the cycle after `start` is sampled in DONE.
- All outputs are registered.

## Structure
- Shared package holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, DONE=2'd3;
  - the byte-lanes-per-word constant (4).
- One sub-module is natural: `word_packer` (lane counter, 32-bit buffer, byte-enable accumulator, clear/push/full outputs).
- The FSM and counters live in the top module.

## Test plan
- Full words:
  - Stimulus: start, then bytes 93 97 17 00 03 a8 88 00 with s_last on the 8th.
  - Required: wr(0, 0x00179793, be=F), then wr(4, 0x0088a803, be=F); done=1, core_rst_n=1, byte_cnt=8, err=0.
- Partial final word:
  - Stimulus: 5 bytes 13 00 00 00 b3, s_last on b3.
  - Required: second write wr(4, 0x000000b3, be=0001).
- Backpressure:
  - Stimulus: s_valid held continuously for 8 bytes.
  - Required: s_ready=0 in each WRITE cycle; no byte lost or duplicated; writes identical to the full-words case.
- Overflow:
  - Stimulus: DEPTH=8, 10 bytes, s_last on the 10th.
  - Required: exactly 2 writes (addr 0 and 4); err=1; byte_cnt=10; done=1.
- Reset mid-load:
  - Stimulus: assert rst_n=0 after 2 bytes.
  - Required: all outputs 0 immediately; no write issued; a fresh load afterwards is correct.
- Restart:
  - Stimulus: `start` during LOAD.
  - Required: ignored.
  - Stimulus: `start` in DONE.
  - Required: core_rst_n falls next cycle; err and byte_cnt cleared.
